// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU execution controller.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    BREAK = 2'd2
  } exec_state_t;

  typedef enum logic [1:0] {
    NONE       = 2'd0,
    USER       = 2'd1,
    BREAKPOINT = 2'd2,
    EBREAK     = 2'd3
  } halt_cause_t;

  localparam logic [31:0] EBREAK_WORD = 32'h00100073;

endpackage

// File: rtl/key_debouncer.sv
// Synchronizes and debounces an active-low pushbutton; emits a one-cycle
// pulse only on an accepted released->pressed transition.
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic press_pulse
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    // Any sample matching the accepted level restarts the stability count.
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_pulse = press_q;

endmodule

// File: rtl/cpu_exec_controller.sv
// Generates the single-cycle commit enable for the monocycle core:
// manual step, divided free-run, PC breakpoint and EBREAK halts.
module cpu_exec_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned RUN_DIV         = 5000000,
  parameter logic [31:0] EBREAK_WORD     = cpu_ctrl_pkg::EBREAK_WORD
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        step_key_n,
  input  logic        run_sw,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc_value,
  input  logic [31:0] instruction,
  output logic        cpu_step_en,
  output logic [1:0]  exec_state,
  output logic [1:0]  halt_cause,
  output logic [31:0] retired_count
);

  import cpu_ctrl_pkg::*;

  localparam int unsigned DW = $clog2(RUN_DIV);

  logic          press;
  exec_state_t   state_q, state_d;
  halt_cause_t   cause_q, cause_d;
  logic          step_q, step_d;
  logic          skip_q, skip_d;
  logic [31:0]   retired_q, retired_d;
  logic [DW-1:0] div_q, div_d;
  logic          terminal;
  logic          bp_hit;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debouncer (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_n      (step_key_n),
    .press_pulse(press)
  );

  assign terminal = (div_q == DW'(RUN_DIV - 1));
  assign bp_hit   = bp_en && (pc_value == bp_addr) && !skip_q;

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    step_d    = 1'b0;
    skip_d    = skip_q;
    div_d     = div_q;
    retired_d = step_q ? retired_q + 32'd1 : retired_q;
    unique case (state_q)
      HALT: begin
        if (run_sw) begin
          state_d = RUN;
          cause_d = NONE;
          skip_d  = 1'b1;
          div_d   = '0;
        end else if (press) begin
          step_d = 1'b1;
        end
      end
      RUN: begin
        div_d = terminal ? '0 : div_q + 1'b1;
        if (!run_sw) begin
          state_d = HALT;
          cause_d = USER;
        end else if (terminal) begin
          if (instruction == EBREAK_WORD) begin
            state_d = BREAK;
            cause_d = EBREAK;
          end else if (bp_hit) begin
            state_d = BREAK;
            cause_d = BREAKPOINT;
          end else begin
            step_d = 1'b1;
            skip_d = 1'b0;
          end
        end
      end
      BREAK: begin
        if (!run_sw) state_d = HALT;
      end
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= HALT;
      cause_q   <= NONE;
      step_q    <= 1'b0;
      skip_q    <= 1'b0;
      div_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      step_q    <= step_d;
      skip_q    <= skip_d;
      div_q     <= div_d;
      retired_q <= retired_d;
    end
  end

  assign cpu_step_en   = step_q;
  assign exec_state    = state_q;
  assign halt_cause    = cause_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_cpu_exec_controller.sv
// Randomized scoreboard bench for cpu_exec_controller against an
// event-level reference model (history windows, scheduled decision cycles).
module tb_cpu_exec_controller;

  localparam int DEB = 4;
  localparam int DIV = 8;
  localparam logic [31:0] EBW = 32'h00100073;
  localparam int NCYC = 4000;

  localparam logic [1:0] S_HALT = 2'd0, S_RUN = 2'd1, S_BREAK = 2'd2;
  localparam logic [1:0] C_NONE = 2'd0, C_USER = 2'd1, C_BP = 2'd2, C_EB = 2'd3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        step_key_n = 1'b1;
  logic        run_sw = 1'b0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = '0;
  logic [31:0] pc_value = '0;
  logic [31:0] instruction = '0;
  logic        cpu_step_en;
  logic [1:0]  exec_state;
  logic [1:0]  halt_cause;
  logic [31:0] retired_count;

  cpu_exec_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .RUN_DIV        (DIV)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .step_key_n   (step_key_n),
    .run_sw       (run_sw),
    .bp_en        (bp_en),
    .bp_addr      (bp_addr),
    .pc_value     (pc_value),
    .instruction  (instruction),
    .cpu_step_en  (cpu_step_en),
    .exec_state   (exec_state),
    .halt_cause   (halt_cause),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  st;
    logic [1:0]  cause;
    logic        step;
    logic [31:0] ret;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  // Reference model state: values the DUT should hold after the coming edge.
  logic [1:0]  m_state, m_cause;
  bit          m_step, m_skip, m_acc, m_press;
  logic [31:0] m_ret, m_pc;
  longint      m_cyc = 0, m_next_dec = 0;
  bit          raw_hist[$];
  bit          syn_hist[$];
  int          pulses = 0;

  task automatic model_step();
    bit press_now, synced, all_diff, new_step;
    m_cyc++;
    if (!reset_n) begin
      m_state = S_HALT; m_cause = C_NONE; m_step = 0; m_ret = '0;
      m_skip = 0; m_acc = 1; m_press = 0; m_pc = '0;
      raw_hist = '{1'b1, 1'b1};
      syn_hist.delete();
    end else begin
      // The core commits on the edge where the enable is high.
      if (m_step) begin
        m_ret++;
        m_pc = (m_pc + 32'd4) & 32'h3C;
      end
      press_now = m_press;
      // Key path: two-stage delay, then a level is accepted once DEB
      // consecutive delayed samples disagree with the accepted level.
      raw_hist.push_back(step_key_n);
      synced = raw_hist[0];
      if (raw_hist.size() > 2) void'(raw_hist.pop_front());
      syn_hist.push_back(synced);
      if (syn_hist.size() > DEB) void'(syn_hist.pop_front());
      m_press = 0;
      all_diff = (syn_hist.size() == DEB);
      foreach (syn_hist[i]) if (syn_hist[i] == m_acc) all_diff = 0;
      if (all_diff) begin
        m_acc = ~m_acc;
        m_press = (m_acc == 0);
        syn_hist.delete();
      end
      new_step = 0;
      case (m_state)
        S_HALT: begin
          if (run_sw) begin
            m_state = S_RUN; m_cause = C_NONE; m_skip = 1;
            m_next_dec = m_cyc + DIV;
          end else if (press_now) new_step = 1;
        end
        S_RUN: begin
          if (!run_sw) begin
            m_state = S_HALT; m_cause = C_USER;
          end else if (m_cyc == m_next_dec) begin
            m_next_dec += DIV;
            if (instruction == EBW) begin
              m_state = S_BREAK; m_cause = C_EB;
            end else if (bp_en && pc_value == bp_addr && !m_skip) begin
              m_state = S_BREAK; m_cause = C_BP;
            end else begin
              new_step = 1; m_skip = 0;
            end
          end
        end
        default: if (!run_sw) m_state = S_HALT;
      endcase
      m_step = new_step;
      if (new_step) pulses++;
    end
    exp_q.push_back('{st: m_state, cause: m_cause, step: m_step, ret: m_ret});
  endtask

  // Monitor: compares every registered output one time unit after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cpu_step_en", {31'd0, cpu_step_en}, {31'd0, e.step});
        chk("exec_state", {30'd0, exec_state}, {30'd0, e.st});
        chk("halt_cause", {30'd0, halt_cause}, {30'd0, e.cause});
        chk("retired_count", retired_count, e.ret);
      end
    end
  end

  initial begin
    int key_hold;
    key_hold = 0;
    m_pc = '0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (cyc < 2) reset_n = 1'b0;
      else reset_n = ($urandom_range(0, 299) != 0);
      if (cyc >= 2 && cyc < 20) begin
        step_key_n = (cyc < 8);
      end else if (key_hold == 0) begin
        step_key_n = $urandom_range(0, 1);
        key_hold = $urandom_range(1, 12);
      end else begin
        key_hold--;
      end
      if (cyc > 40 && $urandom_range(0, 39) == 0) run_sw = ~run_sw;
      if ($urandom_range(0, 49) == 0) bp_en = ~bp_en;
      if ($urandom_range(0, 49) == 0) bp_addr = 32'($urandom_range(0, 15)) << 2;
      instruction = ($urandom_range(0, 7) == 0) ? EBW : ($urandom() | 32'h8000_0000);
      pc_value = m_pc;
      model_step();
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    if (pulses == 0) chk("pulses_seen", 32'(pulses), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
